// File: rtl/irq_latch_pkg.sv
// ----------------------------------------------------------------------------
// irq_latch_pkg
// Shared constants and helpers for the interrupt latch controller.
//   REG_*          : register indices of the 4-entry CPU bus window
//   MAX_SRC        : widest supported source count (register width)
//   ID_W           : width of the encoded interrupt id
//   lowest_set_idx : priority encoder, bit 0 has the highest priority
// ----------------------------------------------------------------------------
package irq_latch_pkg;

  localparam int MAX_SRC = 8;
  localparam int ID_W    = 3;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_OVERRUN = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef logic [MAX_SRC-1:0] src_vec_t;

  // Scan from the top down so the last hit (lowest index) wins; an empty
  // vector encodes as 0.
  function automatic logic [ID_W-1:0] lowest_set_idx(input src_vec_t v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_latch_ctrl_cell.sv
// ----------------------------------------------------------------------------
// irq_src_cell
// Latch for a single interrupt source: previous-sample, pending and overrun
// flops plus the set/clear/overrun logic.
//   clk        : system clock
//   RESETn     : synchronous active-low reset
//   level_mode : 1 = level-sensitive, 0 = rising-edge
//   src        : interrupt request input
//   clr        : clear pending (ack or write-1 to PENDING)
//   ovr_clr    : clear the sticky overrun bit
//   pending    : latched request
//   overrun    : sticky "event arrived while already pending" flag
// ----------------------------------------------------------------------------
module irq_src_cell (
  input  logic clk,
  input  logic RESETn,
  input  logic level_mode,
  input  logic src,
  input  logic clr,
  input  logic ovr_clr,
  output logic pending,
  output logic overrun
);

  logic prev_q,    prev_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic edge_evt;
  logic set_evt;
  logic ovr_set;

  always_comb begin
    edge_evt  = src & ~prev_q;
    set_evt   = level_mode ? src : edge_evt;
    // A set beats a simultaneous clear so no new event is ever dropped.
    // In level mode this also makes a clear ineffective while src is high.
    pending_d = set_evt ? 1'b1 : (clr ? 1'b0 : pending_q);
    ovr_set   = ~level_mode & edge_evt & pending_q & ~clr;
    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
    prev_d    = src;
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      // prev starts high so a source already asserted at release is ignored.
      prev_q    <= 1'b1;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/irq_latch_ctrl.sv
// ----------------------------------------------------------------------------
// irq_latch_ctrl
// NUM_SRC independently latched, maskable, prioritised interrupt sources
// driving an active-low CPU IRQ line, with a 4-register bus window.
//   clk       : system clock
//   RESETn    : synchronous active-low reset
//   irq_src   : interrupt request inputs
//   ack_n     : per-source active-low hardware acknowledge
//   cs/we     : register select / write enable
//   addr      : register index (PENDING, MASK, OVERRUN, STATUS)
//   wdata     : write data
//   rdata     : combinational read data, 0 when not selected
//   irq_n     : registered active-low interrupt request
//   irq_id    : registered index of highest-priority active source
//   irq_valid : registered "any unmasked source pending"
// ----------------------------------------------------------------------------
module irq_latch_ctrl
  import irq_latch_pkg::*;
#(
  parameter int         NUM_SRC    = 4,
  parameter logic [7:0] LEVEL_MODE = 8'h00,
  parameter logic [7:0] RESET_MASK = 8'hFF
) (
  input  logic               clk,
  input  logic               RESETn,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] ack_n,
  input  logic               cs,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  output logic               irq_n,
  output logic [ID_W-1:0]    irq_id,
  output logic               irq_valid
);

  // Bits at NUM_SRC and above are held at zero everywhere.
  localparam int unsigned SRC_BITS_I = (1 << NUM_SRC) - 1;
  localparam src_vec_t    SRC_BITS   = SRC_BITS_I[MAX_SRC-1:0];

  logic      wr_pending;
  logic      wr_mask;
  logic      wr_overrun;
  src_vec_t  pend_vec;
  src_vec_t  ovr_vec;
  src_vec_t  active;
  src_vec_t  mask_q,      mask_d;
  logic      irq_valid_q, irq_valid_d;
  logic      irq_n_q,     irq_n_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;

  assign wr_pending = cs & we & (addr == REG_PENDING);
  assign wr_mask    = cs & we & (addr == REG_MASK);
  assign wr_overrun = cs & we & (addr == REG_OVERRUN);

  genvar gi;
  generate
    for (gi = 0; gi < MAX_SRC; gi++) begin : g_src
      if (gi < NUM_SRC) begin : g_used
        irq_src_cell u_cell (
          .clk        (clk),
          .RESETn     (RESETn),
          .level_mode (LEVEL_MODE[gi]),
          .src        (irq_src[gi]),
          .clr        (~ack_n[gi] | (wr_pending & wdata[gi])),
          .ovr_clr    (wr_overrun & wdata[gi]),
          .pending    (pend_vec[gi]),
          .overrun    (ovr_vec[gi])
        );
      end else begin : g_unused
        assign pend_vec[gi] = 1'b0;
        assign ovr_vec[gi]  = 1'b0;
      end
    end
  endgenerate

  // Masking only gates the request path; latching is unaffected.
  always_comb begin
    mask_d      = wr_mask ? (wdata & SRC_BITS) : mask_q;
    active      = pend_vec & mask_q;
    irq_valid_d = |active;
    irq_n_d     = ~irq_valid_d;
    irq_id_d    = lowest_set_idx(active);
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      mask_q      <= RESET_MASK & SRC_BITS;
      irq_valid_q <= 1'b0;
      irq_n_q     <= 1'b1;
      irq_id_q    <= '0;
    end else begin
      mask_q      <= mask_d;
      irq_valid_q <= irq_valid_d;
      irq_n_q     <= irq_n_d;
      irq_id_q    <= irq_id_d;
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (cs) begin
      case (addr)
        REG_PENDING: rdata = pend_vec;
        REG_MASK:    rdata = mask_q;
        REG_OVERRUN: rdata = ovr_vec;
        default:     rdata = {irq_valid_q, 4'b0000, irq_id_q};
      endcase
    end
  end

  assign irq_n     = irq_n_q;
  assign irq_id    = irq_id_q;
  assign irq_valid = irq_valid_q;

endmodule

// File: tb/tb_irq_latch_ctrl.sv
module tb_irq_latch_ctrl;

  logic       clk;
  logic       RESETn;
  logic [3:0] irq_src;
  logic [3:0] ack_n;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;

  logic [7:0] rdata_e, rdata_l;
  logic       irq_n_e, irq_n_l;
  logic [2:0] irq_id_e, irq_id_l;
  logic       irq_valid_e, irq_valid_l;

  // Edge-mode instance (main) and a level-mode instance on src0.
  irq_latch_ctrl #(.NUM_SRC(4), .LEVEL_MODE(8'h00), .RESET_MASK(8'hFF)) u_dut (
    .clk(clk), .RESETn(RESETn), .irq_src(irq_src), .ack_n(ack_n),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_e), .irq_n(irq_n_e), .irq_id(irq_id_e), .irq_valid(irq_valid_e)
  );

  irq_latch_ctrl #(.NUM_SRC(4), .LEVEL_MODE(8'h01), .RESET_MASK(8'hFF)) u_lvl (
    .clk(clk), .RESETn(RESETn), .irq_src(irq_src), .ack_n(ack_n),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_l), .irq_n(irq_n_l), .irq_id(irq_id_l), .irq_valid(irq_valid_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entry: which DUT, which output, expected value, due cycle.
  typedef struct {
    int         due;
    int         which;   // 0 = edge DUT, 1 = level DUT
    int         sel;     // 0 irq_n, 1 irq_id, 2 irq_valid, 3 rdata
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: pops every expectation due this cycle and compares on negedge.
  exp_t       e;
  logic [7:0] act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0:       act = {7'd0, (e.which == 0) ? irq_n_e     : irq_n_l};
        1:       act = {5'd0, (e.which == 0) ? irq_id_e    : irq_id_l};
        2:       act = {7'd0, (e.which == 0) ? irq_valid_e : irq_valid_l};
        default: act = (e.which == 0) ? rdata_e : rdata_l;
      endcase
      n_cmp++;
      if (e.due != cyc || act !== e.val) begin
        n_bad++;
        $display("FAIL %s: got 8'h%02h expected 8'h%02h (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.due);
      end else begin
        $display("ok   %s: 8'h%02h (cycle %0d)", e.name, act, cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int which, input int sel, input logic [7:0] v, input string nm);
    exp_t x;
    x.due = cyc; x.which = which; x.sel = sel; x.val = v; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic chk_out(input int which, input logic n, input logic [2:0] id,
                         input logic v, input string nm);
    push(which, 0, {7'd0, n},  {nm, ".irq_n"});
    push(which, 1, {5'd0, id}, {nm, ".irq_id"});
    push(which, 2, {7'd0, v},  {nm, ".irq_valid"});
  endtask

  task automatic rd(input int which, input logic [1:0] a, input logic [7:0] v, input string nm);
    cs = 1'b1; we = 1'b0; addr = a;
    push(which, 3, v, nm);
    step(1);
    cs = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    step(1);
    cs = 1'b0; we = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; irq_src = 4'b0001; ack_n = 4'hF;
    cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;

    // --- reset with src0 already high ---
    step(3);
    chk_out(0, 1'b1, 3'd0, 1'b0, "rst_out");
    rd(0, 2'd1, 8'h0F, "rst_mask");
    rd(0, 2'd0, 8'h00, "rst_pending");
    RESETn = 1'b1;
    step(3);
    chk_out(0, 1'b1, 3'd0, 1'b0, "held_src_no_fire");
    rd(0, 2'd0, 8'h00, "held_src_pending");
    irq_src = 4'b0000; step(1);
    irq_src = 4'b0001; step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "src0_one_clk");
    rd(0, 2'd0, 8'h01, "src0_pending");
    chk_out(0, 1'b0, 3'd0, 1'b1, "src0_two_clk");
    rd(0, 2'd3, 8'h80, "src0_status");
    irq_src = 4'b0000;
    wr(2'd0, 8'h01);
    step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "src0_cleared");

    // --- priority: src2 then src1 ---
    irq_src = 4'b0100; step(1);
    irq_src = 4'b0010; step(1);
    irq_src = 4'b0000; step(2);
    chk_out(0, 1'b0, 3'd1, 1'b1, "prio_1_over_2");
    ack_n = 4'b1101; step(1);
    ack_n = 4'b1111;
    chk_out(0, 1'b0, 3'd1, 1'b1, "ack1_same_cycle");
    step(1);
    chk_out(0, 1'b0, 3'd2, 1'b1, "ack1_next_id");
    rd(0, 2'd0, 8'h04, "after_ack1_pending");
    wr(2'd0, 8'h04);
    chk_out(0, 1'b0, 3'd2, 1'b1, "wr_clr_one_clk");
    step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "wr_clr_two_clk");

    // --- masking ---
    wr(2'd1, 8'h00);
    irq_src = 4'b1000; step(1);
    irq_src = 4'b0000; step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "masked_src3_out");
    rd(0, 2'd0, 8'h08, "masked_src3_pending");
    wr(2'd1, 8'h08);
    chk_out(0, 1'b1, 3'd0, 1'b0, "unmask_write_cycle");
    step(1);
    chk_out(0, 1'b0, 3'd3, 1'b1, "unmask_next_cycle");
    rd(0, 2'd1, 8'h08, "mask_readback");
    wr(2'd0, 8'h08);
    wr(2'd1, 8'hFF);
    step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "src3_cleared");
    rd(0, 2'd1, 8'h0F, "mask_upper_ignored");

    // --- overrun ---
    irq_src = 4'b0001; step(1);
    irq_src = 4'b0000; step(1);
    irq_src = 4'b0001; step(1);
    irq_src = 4'b0000; step(1);
    rd(0, 2'd2, 8'h01, "overrun_set");
    rd(0, 2'd0, 8'h01, "overrun_pending");
    wr(2'd2, 8'h01);
    rd(0, 2'd2, 8'h00, "overrun_cleared");
    rd(0, 2'd0, 8'h01, "overrun_pending_kept");

    // --- event and ack in the same cycle: set wins, no overrun ---
    irq_src = 4'b0001; ack_n = 4'b1110; step(1);
    irq_src = 4'b0000; ack_n = 4'b1111;
    rd(0, 2'd0, 8'h01, "set_beats_clear");
    rd(0, 2'd2, 8'h00, "set_clear_no_overrun");
    ack_n = 4'b1110; step(1);
    ack_n = 4'b1111;
    rd(0, 2'd0, 8'h00, "ack0_clears");
    step(1);
    chk_out(0, 1'b1, 3'd0, 1'b0, "idle_after_ack0");

    // --- reset mid-operation beats write, ack and event ---
    irq_src = 4'b0100; step(1);
    irq_src = 4'b0000; step(2);
    chk_out(0, 1'b0, 3'd2, 1'b1, "pre_reset_active");
    RESETn = 1'b0; irq_src = 4'b0001; ack_n = 4'b0000;
    cs = 1'b1; we = 1'b1; addr = 2'd1; wdata = 8'h00;
    step(1);
    cs = 1'b0; we = 1'b0; ack_n = 4'b1111; irq_src = 4'b0000;
    chk_out(0, 1'b1, 3'd0, 1'b0, "mid_reset_out");
    rd(0, 2'd1, 8'h0F, "mid_reset_mask");
    rd(0, 2'd0, 8'h00, "mid_reset_pending");
    RESETn = 1'b1;
    step(1);

    // --- level mode on src0 ---
    irq_src = 4'b0001; step(2);
    wr(2'd0, 8'h01);
    rd(1, 2'd0, 8'h01, "lvl_clr_while_high");
    chk_out(1, 1'b0, 3'd0, 1'b1, "lvl_irq_asserted");
    irq_src = 4'b0000; step(1);
    rd(1, 2'd0, 8'h01, "lvl_held_after_drop");
    wr(2'd0, 8'h01);
    rd(1, 2'd0, 8'h00, "lvl_clr_while_low");
    step(1);
    chk_out(1, 1'b1, 3'd0, 1'b0, "lvl_irq_released");
    irq_src = 4'b0001; step(3);
    chk_out(1, 1'b0, 3'd0, 1'b1, "lvl_reassert");
    RESETn = 1'b0; step(1);
    chk_out(1, 1'b1, 3'd0, 1'b0, "lvl_mid_reset_out");
    rd(1, 2'd0, 8'h00, "lvl_mid_reset_pending");
    RESETn = 1'b1; irq_src = 4'b0000;
    step(2);

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
